deserializer_align: RTL and testbench
=====================================

// Module: deserializer_align
// PURPOSE
//  Receive-side stage downstream of the 8b/10b serializer. Shifts in the serial
//  line one bit per clk and locates word boundaries by hunting for the K28.5
//  comma. Emits aligned 10-bit symbols with a one-cycle valid strobe toward the
//  10b/8b decoder, and reports link lock status.
// PARAMETERS
//  LOCK_COMMAS  3  aligned commas (incl. the first) needed to go SYNC->LOCKED
//  ERR_LIMIT    4  misaligned commas tolerated in LOCKED before returning to HUNT
// PORTS
//  clk        in   1   bit clock, one serial bit per rising edge
//  reset      in   1   synchronous, active-high reset
//  in_data    in   1   serial line bit (first bit of a symbol = out_10b[9])
//  out_10b    out  10  aligned symbol, first-received bit in [9]
//  out_valid  out  1   1-cycle pulse: out_10b holds a new symbol
//  comma_det  out  1   1-cycle pulse: K28.5 seen in window (any phase)
//  locked     out  1   high while in LOCKED
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset).
//  Reset: sr=0, out_10b=0, out_valid=0, comma_det=0, locked=0, state=HUNT,
//   bit_cnt=0, comma_cnt=0, err_cnt=0. reset wins over all other events.
//  Datapath: sr <= {sr[8:0],in_data} every cycle; win = {sr[8:0],in_data}.
//   comma = (win==10'b0011111010) || (win==10'b1100000101) (RD-/RD+ K28.5).
//   comma_det <= comma (registered, all states).
//  Phase: bit_cnt 0..9, wraps 9->0; boundary = (bit_cnt==9). On any realign
//   bit_cnt <= 0, so next boundary is exactly 10 bits later.
//  Emit: when a word is accepted, out_10b <= win, out_valid <= 1 next cycle;
//   otherwise out_valid <= 0, out_10b holds. Latency: strobe 1 cycle after
//   the symbol's 10th bit is sampled.
//  HUNT: bit_cnt free-runs, no emit. comma -> realign, emit, comma_cnt<=1,
//   state<=SYNC (if LOCK_COMMAS==1 go straight to LOCKED).
//  SYNC: boundary -> emit; if comma, comma_cnt++; reaching LOCK_COMMAS ->
//   LOCKED, err_cnt<=0. Non-comma boundary words do not reset comma_cnt.
//   comma at non-boundary -> realign, emit, comma_cnt<=1, stay SYNC.
//  LOCKED: locked=1 (registered, asserts with the locking symbol's strobe).
//   boundary -> emit; comma at boundary -> err_cnt<=0. comma off boundary ->
//   err_cnt++, no realign, no emit; reaching ERR_LIMIT -> HUNT, locked<=0,
//   comma_cnt<=0, no realign that cycle (next comma restarts acquisition).
//  Counters saturate at their limit; widths $clog2(limit+1).
//  Reset mid-word discards partial symbol; no strobe until new comma found.
// TESTING
//  1 reset held 5 clk with random in_data -> all outputs 0, no strobes.
//  2 idle 0s, then 3x K28.5 RD- (0011111010) back-to-back -> out_valid at
//    bits 10/20/30 (+1 cycle), out_10b=0x0FA each, locked high with 3rd strobe.
//  3 locked, stream D21.5 (1010101010) x8 -> out_valid every 10 clk,
//    out_10b=0x2AA, comma_det never, locked stays 1.
//  4 locked, inject 1 extra bit then commas -> 4 misaligned commas -> locked
//    falls after 4th, HUNT; next comma reacquires, relock after 3 at new phase.
//  5 SYNC after 1 comma, slip 3 bits, comma -> realign at new phase, comma_cnt
//    restarts; alternate RD+ 0x305 / RD- 0x0FA commas lock identically.
//  6 assert reset 1 cycle mid-symbol while locked -> next cycle locked=0,
//    out_valid=0, HUNT; resumes lock after 3 aligned commas.

Source files
------------

// File: rtl/deserializer_align.sv
// deserializer_align: serial-to-10b receive stage with K28.5 comma alignment.
// Shifts in one line bit per clk, hunts for the comma to find word boundaries,
// emits aligned symbols with a one-cycle strobe and tracks link lock.
module deserializer_align #(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_data,
  output logic [9:0] out_10b,
  output logic       out_valid,
  output logic       comma_det,
  output logic       locked
);

  localparam int CW = $clog2(LOCK_COMMAS + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [CW-1:0] COMMA_MAX = CW'(LOCK_COMMAS);
  localparam logic [EW-1:0] ERR_MAX   = EW'(ERR_LIMIT);
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t          state_q, state_d;
  // The oldest history bit drops out of every window, so nine bits suffice.
  logic [8:0]      sr_q, sr_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   comma_cnt_q, comma_cnt_d;
  logic [EW-1:0]   err_cnt_q, err_cnt_d;
  logic [9:0]      out_10b_q, out_10b_d;
  logic            out_valid_q, out_valid_d;
  logic            comma_det_q, comma_det_d;
  logic            locked_q, locked_d;

  logic [9:0]      win;
  logic            comma;
  logic            boundary;
  logic [CW-1:0]   comma_inc;
  logic [EW-1:0]   err_inc;

  assign win      = {sr_q, in_data};
  assign comma    = (win == K28_5_RDN) || (win == K28_5_RDP);
  assign boundary = (bit_cnt_q == 4'd9);

  // Next-state, phase tracking and symbol emit decisions for the alignment FSM.
  always_comb begin
    sr_d        = win[8:0];
    comma_det_d = comma;
    out_10b_d   = out_10b_q;
    out_valid_d = 1'b0;
    bit_cnt_d   = boundary ? 4'd0 : bit_cnt_q + 4'd1;
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    comma_inc   = (comma_cnt_q == COMMA_MAX) ? COMMA_MAX : comma_cnt_q + CW'(1);
    err_inc     = (err_cnt_q == ERR_MAX) ? ERR_MAX : err_cnt_q + EW'(1);

    case (state_q)
      HUNT: begin
        if (comma) begin
          bit_cnt_d   = 4'd0;
          out_10b_d   = win;
          out_valid_d = 1'b1;
          comma_cnt_d = CW'(1);
          if (LOCK_COMMAS == 1) begin
            state_d   = LOCKED;
            err_cnt_d = '0;
          end else begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        if (boundary) begin
          out_10b_d   = win;
          out_valid_d = 1'b1;
          if (comma) begin
            comma_cnt_d = comma_inc;
            if (comma_inc == COMMA_MAX) begin
              state_d   = LOCKED;
              err_cnt_d = '0;
            end
          end
        end else if (comma) begin
          // A comma on a new phase restarts acquisition at that phase.
          bit_cnt_d   = 4'd0;
          out_10b_d   = win;
          out_valid_d = 1'b1;
          comma_cnt_d = CW'(1);
          if (LOCK_COMMAS == 1) begin
            state_d   = LOCKED;
            err_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          out_10b_d   = win;
          out_valid_d = 1'b1;
          if (comma) begin
            err_cnt_d = '0;
          end
        end else if (comma) begin
          // Misplaced commas are counted but never move the phase while locked.
          err_cnt_d = err_inc;
          if (err_inc == ERR_MAX) begin
            state_d     = HUNT;
            comma_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      out_10b_q   <= '0;
      out_valid_q <= 1'b0;
      comma_det_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      out_10b_q   <= out_10b_d;
      out_valid_q <= out_valid_d;
      comma_det_q <= comma_det_d;
      locked_q    <= locked_d;
    end
  end

  assign out_10b   = out_10b_q;
  assign out_valid = out_valid_q;
  assign comma_det = comma_det_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_deserializer_align.sv
// tb_deserializer_align: directed bench for deserializer_align with
// hand-computed strobe positions, symbol values and lock status.
module tb_deserializer_align;

  localparam logic [9:0] RDN   = 10'h0FA;
  localparam logic [9:0] RDP   = 10'h305;
  localparam logic [9:0] D21_5 = 10'h2AA;
  localparam logic [9:0] IDLE  = 10'h000;
  localparam logic [9:0] AT10  = 10'b0000000001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_data = 1'b0;
  logic [9:0] out_10b;
  logic       out_valid;
  logic       comma_det;
  logic       locked;

  int vectors = 0;
  int miscompares = 0;

  deserializer_align #(.LOCK_COMMAS(3), .ERR_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .out_10b   (out_10b),
    .out_valid (out_valid),
    .comma_det (comma_det),
    .locked    (locked)
  );

  // Free-running bit clock.
  always #5 clk = ~clk;

  // Drive one bit and reset level away from the edge, then sample just after it.
  task automatic applyStimulus(input logic bit_in, input logic rst_in);
    @(negedge clk);
    in_data = bit_in;
    reset   = rst_in;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Send one 10-bit word MSB first; record strobe and comma pulses per bit.
  task automatic sendWord(input string tag, input logic [9:0] sym,
                          input logic [9:0] exp_vmask, input logic [9:0] exp_data,
                          input logic exp_locked);
    logic [9:0] vmask;
    logic [9:0] cmask;
    logic [9:0] exp_cmask;
    vmask = '0;
    cmask = '0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(sym[9-k], 1'b0);
      vmask = {vmask[8:0], out_valid};
      cmask = {cmask[8:0], comma_det};
    end
    exp_cmask = (sym == RDN || sym == RDP) ? AT10 : 10'b0;
    checkOutput({tag, " valid_mask"}, 32'(vmask), 32'(exp_vmask));
    checkOutput({tag, " out_10b"}, 32'(out_10b), 32'(exp_data));
    checkOutput({tag, " locked"}, 32'(locked), 32'(exp_locked));
    checkOutput({tag, " comma_mask"}, 32'(cmask), 32'(exp_cmask));
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios: reset, acquisition, data, slip, resync, reset mid-word.
  initial begin
    logic any_valid;

    // Reset held with random line data: every output stays zero.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      checkOutput("t1 reset outputs", {out_10b, out_valid, comma_det, locked}, 32'h0);
    end

    // Idle zeros, then three back-to-back RD- commas acquire lock.
    sendWord("t2 idle0", IDLE, 10'b0, 10'h000, 1'b0);
    sendWord("t2 idle1", IDLE, 10'b0, 10'h000, 1'b0);
    sendWord("t2 comma1", RDN, AT10, RDN, 1'b0);
    sendWord("t2 comma2", RDN, AT10, RDN, 1'b0);
    sendWord("t2 comma3", RDN, AT10, RDN, 1'b1);

    // Locked data stream: one strobe per word, no comma pulses.
    for (int i = 0; i < 8; i++) begin
      sendWord($sformatf("t3 d21.5 #%0d", i), D21_5, AT10, D21_5, 1'b1);
    end

    // One extra bit shifts the phase; four misplaced commas drop lock.
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4 extra bit valid", 32'(out_valid), 32'h0);
    sendWord("t4 bad1", RDN, 10'b0000000010, 10'h07D, 1'b1);
    sendWord("t4 bad2", RDN, 10'b0000000010, 10'h07D, 1'b1);
    sendWord("t4 bad3", RDN, 10'b0000000010, 10'h07D, 1'b1);
    sendWord("t4 bad4", RDN, 10'b0000000010, 10'h07D, 1'b0);
    sendWord("t4 reacq1", RDN, AT10, RDN, 1'b0);
    sendWord("t4 reacq2", RDN, AT10, RDN, 1'b0);
    sendWord("t4 reacq3", RDN, AT10, RDN, 1'b1);
    sendWord("t4 data", D21_5, AT10, D21_5, 1'b1);

    // Reset pulse part-way through a word while locked.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t6 locked after reset", 32'(locked), 32'h0);
    checkOutput("t6 valid after reset", 32'(out_valid), 32'h0);
    checkOutput("t6 data after reset", {out_10b, comma_det}, 32'h0);
    any_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'(i % 2), 1'b0);
      any_valid = any_valid | out_valid;
    end
    checkOutput("t6 partial no strobe", 32'(any_valid), 32'h0);
    sendWord("t6 data unlocked", D21_5, 10'b0, 10'h000, 1'b0);
    sendWord("t6 comma1", RDN, AT10, RDN, 1'b0);
    sendWord("t6 comma2", RDN, AT10, RDN, 1'b0);
    sendWord("t6 comma3", RDN, AT10, RDN, 1'b1);

    // Slip in SYNC: realign at the new phase, count restarts; RD+/RD- mixed.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("t5 locked after reset", 32'(locked), 32'h0);
    sendWord("t5 idle", IDLE, 10'b0, 10'h000, 1'b0);
    sendWord("t5 comma1 rd-", RDN, AT10, RDN, 1'b0);
    sendWord("t5 comma2 rd+", RDP, AT10, RDP, 1'b0);
    any_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      any_valid = any_valid | out_valid;
    end
    checkOutput("t5 slip bits no strobe", 32'(any_valid), 32'h0);
    sendWord("t5 realign rd-", RDN, 10'b0000001001, RDN, 1'b0);
    sendWord("t5 comma2 rd+ new", RDP, AT10, RDP, 1'b0);
    sendWord("t5 comma3 rd- new", RDN, AT10, RDN, 1'b1);
    sendWord("t5 data new phase", D21_5, AT10, D21_5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
